// File: rtl/sc_level_controller.sv
// Frogger level sequencer: edge-detects frog events, drives nest-register strobes, tracks lives/level, win/game-over.
// Latency: input falling edge -> event register -> strobe registered with the next state (2 clocks); strobes are 1 clock wide.
// No backpressure: events outside their accepting states are dropped; SC_LEVELCTRL_TIMEOUT_EN adds a PLAY time limit.
module sc_level_controller #(
    parameter int NEST_WIDTH      = 2,
    parameter int NESTS_PER_LEVEL = 2,
    parameter int LIVES_INIT      = 3,
    parameter int LEVEL_MAX       = 3,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic                  SC_LEVELCTRL_CLOCK_50,
    input  logic                  SC_LEVELCTRL_RESET_InHigh,
    input  logic                  SC_LEVELCTRL_start_InLow,
    input  logic                  SC_LEVELCTRL_nest_reached_InLow,
    input  logic                  SC_LEVELCTRL_collision_InLow,
    input  logic [NEST_WIDTH-1:0] SC_LEVELCTRL_nest_count_InBUS,
    output logic                  SC_LEVELCTRL_nest_clear_OutLow,
    output logic                  SC_LEVELCTRL_nest_inc_OutLow,
    output logic                  SC_LEVELCTRL_frog_reset_OutLow,
    output logic [1:0]            SC_LEVELCTRL_level_OutBUS,
    output logic [1:0]            SC_LEVELCTRL_lives_OutBUS,
    output logic [2:0]            SC_LEVELCTRL_state_OutBUS,
    output logic                  SC_LEVELCTRL_gameover_OutLow,
    output logic                  SC_LEVELCTRL_win_OutLow
);

    typedef enum logic [2:0] {
        stIdle    = 3'd0,
        stInit    = 3'd1,
        stPlay    = 3'd2,
        stNest    = 3'd3,
        stCheck   = 3'd4,
        stLevelUp = 3'd5,
        stDeath   = 3'd6,
        stEnd     = 3'd7
    } stateType;

    stateType   state;
    logic       startPrev, nestPrev, collPrev;
    logic       startEvt, nestEvt, collEvt;
    logic       timeoutHit;
    logic [1:0] level, lives;
    logic       nestClear, nestInc, frogReset, win, gameover;

    // Events are registered so each held-low input yields exactly one single-cycle event.
    always_ff @(posedge SC_LEVELCTRL_CLOCK_50 or posedge SC_LEVELCTRL_RESET_InHigh) begin
        if (SC_LEVELCTRL_RESET_InHigh) begin
            startPrev <= 1'b1;
            nestPrev  <= 1'b1;
            collPrev  <= 1'b1;
            startEvt  <= 1'b0;
            nestEvt   <= 1'b0;
            collEvt   <= 1'b0;
        end else begin
            startPrev <= SC_LEVELCTRL_start_InLow;
            nestPrev  <= SC_LEVELCTRL_nest_reached_InLow;
            collPrev  <= SC_LEVELCTRL_collision_InLow;
            startEvt  <= startPrev & ~SC_LEVELCTRL_start_InLow;
            nestEvt   <= nestPrev & ~SC_LEVELCTRL_nest_reached_InLow;
            collEvt   <= collPrev & ~SC_LEVELCTRL_collision_InLow;
        end
    end

`ifdef SC_LEVELCTRL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] toCount;

    assign timeoutHit = (state == stPlay) && (toCount == '0);

    always_ff @(posedge SC_LEVELCTRL_CLOCK_50 or posedge SC_LEVELCTRL_RESET_InHigh) begin
        if (SC_LEVELCTRL_RESET_InHigh) begin
            toCount <= TW'(TIMEOUT_CYCLES - 1);
        end else begin
            case (state)
                stInit, stLevelUp, stDeath, stNest: toCount <= TW'(TIMEOUT_CYCLES - 1);
                stPlay: if (toCount != '0) toCount <= toCount - 1'b1;
                default: toCount <= toCount;
            endcase
        end
    end
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT_CYCLES;
    assign timeoutHit    = 1'b0;
`endif

    // Strobes are set together with the state they belong to, so they are low exactly while in it.
    always_ff @(posedge SC_LEVELCTRL_CLOCK_50 or posedge SC_LEVELCTRL_RESET_InHigh) begin
        if (SC_LEVELCTRL_RESET_InHigh) begin
            state     <= stIdle;
            level     <= 2'd0;
            lives     <= 2'(LIVES_INIT);
            nestClear <= 1'b1;
            nestInc   <= 1'b1;
            frogReset <= 1'b1;
            win       <= 1'b1;
            gameover  <= 1'b1;
        end else begin
            nestClear <= 1'b1;
            nestInc   <= 1'b1;
            frogReset <= 1'b1;
            case (state)
                stIdle, stEnd: begin
                    if (startEvt) begin
                        state     <= stInit;
                        nestClear <= 1'b0;
                        frogReset <= 1'b0;
                        level     <= 2'd0;
                        lives     <= 2'(LIVES_INIT);
                        win       <= 1'b1;
                        gameover  <= 1'b1;
                    end
                end
                stInit: state <= stPlay;
                stPlay: begin
                    if (collEvt || timeoutHit) begin
                        state     <= stDeath;
                        frogReset <= 1'b0;
                    end else if (nestEvt) begin
                        state     <= stNest;
                        nestInc   <= 1'b0;
                        frogReset <= 1'b0;
                    end
                end
                stNest: state <= stCheck;
                stCheck: begin
                    if (int'(SC_LEVELCTRL_nest_count_InBUS) >= NESTS_PER_LEVEL) begin
                        state     <= stLevelUp;
                        nestClear <= 1'b0;
                        frogReset <= 1'b0;
                    end else begin
                        state <= stPlay;
                    end
                end
                stLevelUp: begin
                    if (int'(level) + 1 >= LEVEL_MAX) begin
                        state <= stEnd;
                        win   <= 1'b0;
                    end else begin
                        level <= level + 2'd1;
                        state <= stPlay;
                    end
                end
                stDeath: begin
                    if (lives <= 2'd1) begin
                        lives    <= 2'd0;
                        state    <= stEnd;
                        gameover <= 1'b0;
                    end else begin
                        lives <= lives - 2'd1;
                        state <= stPlay;
                    end
                end
                default: state <= stIdle;
            endcase
        end
    end

    assign SC_LEVELCTRL_nest_clear_OutLow = nestClear;
    assign SC_LEVELCTRL_nest_inc_OutLow   = nestInc;
    assign SC_LEVELCTRL_frog_reset_OutLow = frogReset;
    assign SC_LEVELCTRL_level_OutBUS      = level;
    assign SC_LEVELCTRL_lives_OutBUS      = lives;
    assign SC_LEVELCTRL_state_OutBUS      = state;
    assign SC_LEVELCTRL_gameover_OutLow   = gameover;
    assign SC_LEVELCTRL_win_OutLow        = win;

endmodule

// File: tb/tb_sc_level_controller.sv
// Scoreboard bench for sc_level_controller: every state change is popped against a hand-computed snapshot queue.
module tb_sc_level_controller;

    typedef struct packed {
        logic [2:0] st;
        logic       clr;
        logic       inc;
        logic       frog;
        logic [1:0] lvl;
        logic [1:0] lives;
        logic       win;
        logic       gov;
    } snapT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startN = 1'b1;
    logic       nestN = 1'b1;
    logic       collN = 1'b1;
    logic [1:0] nestCount = 2'd0;
    logic       nestClear, nestInc, frogReset, gameover, win;
    logic [1:0] level, lives;
    logic [2:0] state;

    int   checks = 0;
    int   errors = 0;
    int   clrLow = 0;
    int   incLow = 0;
    logic monOn = 1'b0;
    logic [2:0] lastSt = 3'd0;
    snapT expQ[$];

    always #10 clk = ~clk;

    sc_level_controller dut (
        .SC_LEVELCTRL_CLOCK_50          (clk),
        .SC_LEVELCTRL_RESET_InHigh      (rst),
        .SC_LEVELCTRL_start_InLow       (startN),
        .SC_LEVELCTRL_nest_reached_InLow(nestN),
        .SC_LEVELCTRL_collision_InLow   (collN),
        .SC_LEVELCTRL_nest_count_InBUS  (nestCount),
        .SC_LEVELCTRL_nest_clear_OutLow (nestClear),
        .SC_LEVELCTRL_nest_inc_OutLow   (nestInc),
        .SC_LEVELCTRL_frog_reset_OutLow (frogReset),
        .SC_LEVELCTRL_level_OutBUS      (level),
        .SC_LEVELCTRL_lives_OutBUS      (lives),
        .SC_LEVELCTRL_state_OutBUS      (state),
        .SC_LEVELCTRL_gameover_OutLow   (gameover),
        .SC_LEVELCTRL_win_OutLow        (win)
    );

    // Nest register model: clear has priority over increment.
    always @(posedge clk) begin
        if (!nestClear)     nestCount <= 2'd0;
        else if (!nestInc)  nestCount <= nestCount + 2'd1;
    end

    function automatic snapT snap();
        return {state, nestClear, nestInc, frogReset, level, lives, win, gameover};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_s(input logic [2:0] st, input logic clr, input logic inc, input logic frog,
                            input logic [1:0] lvl, input logic [1:0] lv, input logic w, input logic g);
        expQ.push_back({st, clr, inc, frog, lvl, lv, w, g});
    endtask

    // Monitor: compares each new state, with its outputs, against the head of the queue.
    always @(negedge clk) begin
        if (monOn) begin
            if (!nestClear) clrLow++;
            if (!nestInc)   incLow++;
            if (state != lastSt) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transition actual=%0h required=none", snap());
                end else begin
                    chk("transition", 32'(snap()), 32'(expQ.pop_front()));
                end
                lastSt = state;
            end
        end
    end

    // which: 0 start, 1 nest, 2 collision, 3 nest+collision together
    task automatic hit(input int which, input int hold);
        @(posedge clk); #1;
        case (which)
            0: startN = 1'b0;
            1: nestN  = 1'b0;
            2: collN  = 1'b0;
            default: begin nestN = 1'b0; collN = 1'b0; end
        endcase
        repeat (hold) @(posedge clk);
        #1;
        startN = 1'b1; nestN = 1'b1; collN = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

`ifdef SC_LEVELCTRL_TIMEOUT_EN
    logic       tStartN = 1'b1;
    logic       tClr, tInc, tFrog, tGov, tWin;
    logic [1:0] tLevel, tLives;
    logic [2:0] tState;

    sc_level_controller #(.TIMEOUT_CYCLES(20)) dutTo (
        .SC_LEVELCTRL_CLOCK_50          (clk),
        .SC_LEVELCTRL_RESET_InHigh      (rst),
        .SC_LEVELCTRL_start_InLow       (tStartN),
        .SC_LEVELCTRL_nest_reached_InLow(1'b1),
        .SC_LEVELCTRL_collision_InLow   (1'b1),
        .SC_LEVELCTRL_nest_count_InBUS  (2'b00),
        .SC_LEVELCTRL_nest_clear_OutLow (tClr),
        .SC_LEVELCTRL_nest_inc_OutLow   (tInc),
        .SC_LEVELCTRL_frog_reset_OutLow (tFrog),
        .SC_LEVELCTRL_level_OutBUS      (tLevel),
        .SC_LEVELCTRL_lives_OutBUS      (tLives),
        .SC_LEVELCTRL_state_OutBUS      (tState),
        .SC_LEVELCTRL_gameover_OutLow   (tGov),
        .SC_LEVELCTRL_win_OutLow        (tWin)
    );

    task automatic timeout_test();
        int n = 0;
        int playCycles = 0;
        @(posedge clk); #1 tStartN = 1'b0;
        repeat (2) @(posedge clk);
        #1 tStartN = 1'b1;
        while (tState != 3'd2 && n < 20) begin @(negedge clk); n++; end
        while (tState == 3'd2 && playCycles < 100) begin playCycles++; @(negedge clk); end
        chk("timeout_play_cycles", 32'(playCycles), 32'd20);
        chk("timeout_death_state", 32'(tState), 32'd6);
        @(negedge clk);
        chk("timeout_lives", 32'(tLives), 32'd2);
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(snap()), 32'({3'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 1'b1, 1'b1}));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(snap()), 32'({3'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 1'b1, 1'b1}));
        monOn = 1'b1;

        // Start held low for 10 cycles: exactly one INIT
        clrLow = 0;
        expect_s(3'd1, 0, 1, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd2, 1, 1, 1, 2'd0, 2'd3, 1, 1);
        hit(0, 10);
        drain("start_drain");
        chk("init_clear_width", 32'(clrLow), 32'd1);

        // Two nests complete level 0
        expect_s(3'd3, 1, 0, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd4, 1, 1, 1, 2'd0, 2'd3, 1, 1);
        expect_s(3'd2, 1, 1, 1, 2'd0, 2'd3, 1, 1);
        hit(1, 3);
        expect_s(3'd3, 1, 0, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd4, 1, 1, 1, 2'd0, 2'd3, 1, 1);
        expect_s(3'd5, 0, 1, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd2, 1, 1, 1, 2'd1, 2'd3, 1, 1);
        hit(1, 3);
        drain("levelup_drain");
        chk("nest_count_cleared", 32'(nestCount), 32'd0);

        // Three collisions to game over, a fourth is ignored, then restart
        for (int i = 3; i >= 1; i--) begin
            expect_s(3'd6, 1, 1, 0, 2'd1, 2'(i), 1, 1);
            if (i > 1) expect_s(3'd2, 1, 1, 1, 2'd1, 2'(i - 1), 1, 1);
            else       expect_s(3'd7, 1, 1, 1, 2'd1, 2'd0, 1, 0);
            hit(2, 2);
        end
        hit(2, 2);
        drain("gameover_drain");
        expect_s(3'd1, 0, 1, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd2, 1, 1, 1, 2'd0, 2'd3, 1, 1);
        hit(0, 2);
        drain("restart_drain");

        // Collision and nest on the same clock: death only
        incLow = 0;
        expect_s(3'd6, 1, 1, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd2, 1, 1, 1, 2'd0, 2'd2, 1, 1);
        hit(3, 2);
        drain("both_drain");
        chk("both_no_inc", 32'(incLow), 32'd0);

        // Three levels to a win; a nest in END is ignored
        for (int l = 0; l < 3; l++) begin
            expect_s(3'd3, 1, 0, 0, 2'(l), 2'd2, 1, 1);
            expect_s(3'd4, 1, 1, 1, 2'(l), 2'd2, 1, 1);
            expect_s(3'd2, 1, 1, 1, 2'(l), 2'd2, 1, 1);
            hit(1, 2);
            expect_s(3'd3, 1, 0, 0, 2'(l), 2'd2, 1, 1);
            expect_s(3'd4, 1, 1, 1, 2'(l), 2'd2, 1, 1);
            expect_s(3'd5, 0, 1, 0, 2'(l), 2'd2, 1, 1);
            if (l < 2) expect_s(3'd2, 1, 1, 1, 2'(l + 1), 2'd2, 1, 1);
            else       expect_s(3'd7, 1, 1, 1, 2'd2, 2'd2, 0, 1);
            hit(1, 2);
        end
        hit(1, 2);
        drain("win_drain");
        chk("win_level_held", 32'(level), 32'd2);

        // Restart, then reset while in NEST
        expect_s(3'd1, 0, 1, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd2, 1, 1, 1, 2'd0, 2'd3, 1, 1);
        hit(0, 2);
        drain("restart2_drain");
        expect_s(3'd3, 1, 0, 0, 2'd0, 2'd3, 1, 1);
        expect_s(3'd0, 1, 1, 1, 2'd0, 2'd3, 1, 1);
        @(posedge clk); #1 nestN = 1'b0;
        begin
            int n = 0;
            while (state != 3'd3 && n < 10) begin @(negedge clk); n++; end
        end
        chk("reached_nest", 32'(state), 32'd3);
        #2 rst = 1'b1;
        #1 chk("async_reset", 32'(snap()), 32'({3'd0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 1'b1, 1'b1}));
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0; nestN = 1'b1;
        drain("reset_drain");

`ifdef SC_LEVELCTRL_TIMEOUT_EN
        timeout_test();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_level_controller.md
Name: sc_level_controller

Overview:
- Game-level sequencer for the nest register (nest counter with active-low clear/load/increment strobes) and the lives/level bookkeeping.
- Converts raw frog events (nest reached, collision) into single-cycle active-low strobes for the nest register.
- Decides level completion, life loss, win and game over, and drives frog-position restart.
- Sits between the frog/collision detection logic and the nest register, and feeds status buses to the display logic.

Parameters:
- NEST_WIDTH, 2, width of the nest count bus; equals the nest register data width.
- NESTS_PER_LEVEL, 2, nest count that completes a level (2'b10).
- LIVES_INIT, 3, lives loaded at reset and at game start; must be in 1..3.
- LEVEL_MAX, 3, levels to win; level counter is 2 bits, so LEVEL_MAX must be in 1..3.
- TIMEOUT_CYCLES, 50000000, level time limit in clocks; used only with the optional feature.

Ports:
- SC_LEVELCTRL_CLOCK_50  in  1  system clock, 50 MHz.
- SC_LEVELCTRL_RESET_InHigh  in  1  asynchronous reset, active-high.
- SC_LEVELCTRL_start_InLow  in  1  start button, level-held, active-low.
- SC_LEVELCTRL_nest_reached_InLow  in  1  frog inside a nest, level-held, active-low.
- SC_LEVELCTRL_collision_InLow  in  1  frog hit or drowned, level-held, active-low.
- SC_LEVELCTRL_nest_count_InBUS  in  NEST_WIDTH  current nest register output.
- SC_LEVELCTRL_nest_clear_OutLow  out  1  clear strobe to the nest register.
- SC_LEVELCTRL_nest_inc_OutLow  out  1  increment strobe to the nest register (nest-reached input).
- SC_LEVELCTRL_frog_reset_OutLow  out  1  return frog to its start position.
- SC_LEVELCTRL_level_OutBUS  out  2  current level, 0-based.
- SC_LEVELCTRL_lives_OutBUS  out  2  remaining lives.
- SC_LEVELCTRL_state_OutBUS  out  3  FSM state code.
- SC_LEVELCTRL_gameover_OutLow  out  1  game lost.
- SC_LEVELCTRL_win_OutLow  out  1  game won.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, level=0, lives=LIVES_INIT.
  - Edge-detect registers=1.
  - All _OutLow outputs=1.
- Edge detection:
  - Each _InLow input has a registered previous value.
  - event = previous==1 AND current==0.
  - A held-low input therefore produces exactly one event.
- Event rules:
  - Events are acted on only in the states named below; all others are dropped, never queued.
  - Collision and nest events in the same PLAY cycle: collision wins, the nest event is discarded.
- State codes and transitions:
  - IDLE(0): outputs inactive; start event -> INIT.
  - INIT(1), one cycle: nest_clear=0, frog_reset=0, level=0, lives=LIVES_INIT -> PLAY.
  - PLAY(2): collision event -> DEATH; else nest event -> NEST; else stay.
  - NEST(3), one cycle: nest_inc=0, frog_reset=0 -> CHECK.
  - CHECK(4), one cycle: sample nest_count_InBUS, which is already updated.
    - Count >= NESTS_PER_LEVEL -> LEVELUP; else -> PLAY.
  - LEVELUP(5), one cycle: nest_clear=0, frog_reset=0.
    - If level+1 == LEVEL_MAX -> END with win latched, level held.
    - Else level+1 -> PLAY.
  - DEATH(6), one cycle: lives-1, frog_reset=0.
    - If the new lives value is 0 -> END with gameover latched; else -> PLAY.
  - END(7): win_OutLow or gameover_OutLow held 0.
    - Start event -> INIT; INIT also releases both flags.
- Strobe outputs: registered (Moore), 1-clock wide, asserted only in the states listed.
- Nest count beyond NESTS_PER_LEVEL is handled by the >= comparison.
- Lives and level never wrap: lives saturates at 0, level at LEVEL_MAX-1.
- Latency: input edge to nest_inc low = 2 clocks (edge register, then NEST state).

Optional Feature:
- SC_LEVELCTRL_TIMEOUT_EN defined:
  - A down-counter of width clog2(TIMEOUT_CYCLES) is loaded with TIMEOUT_CYCLES-1 in INIT, LEVELUP, DEATH and NEST.
  - It decrements only in PLAY; at 0 in PLAY the FSM enters DEATH, same as a collision.
  - A collision event in the same cycle gives a single DEATH only.
- Undefined: no counter and no timeout path; the module is functionally identical otherwise.

Test Plan:
- Reset then start held low 10 cycles -> one INIT pulse (nest_clear=0 for 1 clock), state=2, lives=3, level=0.
- Two separate nest events with the nest register model in loop -> two nest_inc pulses, count 1 then 2, LEVELUP pulse, level=1, nest_clear pulse.
- Three collisions -> lives 2, 1, 0; state=7; gameover_OutLow=0; further collisions ignored; start -> INIT and lives=3.
- Collision and nest fall on the same clock in PLAY -> DEATH only, lives-1, no nest_inc pulse.
- Complete 3 levels -> win_OutLow=0 in END, level stays 2; RESET_InHigh pulsed mid-NEST -> state=0 immediately, all outputs inactive.
- With SC_LEVELCTRL_TIMEOUT_EN and TIMEOUT_CYCLES=20, idle in PLAY -> DEATH exactly 20 PLAY cycles after entry, lives-1.
